bank_channel_credit_return: RTL



---
 rtl/bank_pkg.sv | 9 +
 rtl/bank_credit_fifo.sv | 56 +++++
 rtl/bank_channel_credit_return.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Constants and types shared by the bank issue and return sides.
// The return-side FIFO depth and the issue-side reset credit count both come
// from CREDIT_NUM, so the two ends cannot disagree.
package bank_pkg;
  localparam int CHANNEL_NUM = 3;
  localparam int CREDIT_NUM  = 8;

  typedef logic [1:0] ch_id_t;
endpackage

// File: rtl/bank_credit_fifo.sv
// Per-channel response FIFO. The depth is a power of two, so the pointers
// wrap naturally. A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module bank_credit_fifo
  import bank_pkg::*;
#(
  parameter int DEPTH = CREDIT_NUM,
  parameter int WIDTH = 72
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  // storage array; contents past the head are don't-care, so no reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/bank_channel_credit_return.sv
// Read-return buffer: one FIFO per channel, drained through one round-robin
// response port. Every handshake returns one credit to the issue side as a
// registered one-cycle pulse. The grant is locked while a response stalls.
module bank_channel_credit_return #(
  parameter int CHANNEL_NUM = bank_pkg::CHANNEL_NUM,
  parameter int CREDIT_NUM  = bank_pkg::CREDIT_NUM,
  parameter int TAG_WIDTH   = 8,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rd_issue_valid,
  input  bank_pkg::ch_id_t                  rd_issue_ch_id,
  input  logic [CHANNEL_NUM-1:0]            ch_rsp_valid,
  input  logic [CHANNEL_NUM*TAG_WIDTH-1:0]  ch_rsp_tag,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] ch_rsp_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output bank_pkg::ch_id_t                  rsp_ch_id,
  output logic [TAG_WIDTH-1:0]              rsp_tag,
  output logic [DATA_WIDTH-1:0]             rsp_data,
  output logic [CHANNEL_NUM-1:0]            channels_credit_release,
  output logic                              err_credit_overrun,
  output logic                              err_unexpected_rsp
);
  localparam int OW = $clog2(CREDIT_NUM + 1);
  localparam int EW = TAG_WIDTH + DATA_WIDTH;
  localparam logic [OW-1:0] CRED_MAX = OW'(CREDIT_NUM);
  localparam logic [OW:0]   CRED_SUM = (OW+1)'(CREDIT_NUM);

  logic [CHANNEL_NUM-1:0]         empty_v, full_v, push_v, pop_v;
  logic [CHANNEL_NUM-1:0]         issue_v, ovr_v, unx_v, credit_rel;
  logic [CHANNEL_NUM-1:0][EW-1:0] head, wdata;
  logic [CHANNEL_NUM-1:0][OW-1:0] cnt, outstanding;
  bank_pkg::ch_id_t               rr_ptr, grant, lock_ch;
  logic                           locked, any_vld, hs;
  logic [EW-1:0]                  head_g;

  assign push_v = ch_rsp_valid;

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    assign wdata[g] = {ch_rsp_tag[g*TAG_WIDTH +: TAG_WIDTH],
                       ch_rsp_data[g*DATA_WIDTH +: DATA_WIDTH]};

    bank_credit_fifo #(.DEPTH(CREDIT_NUM), .WIDTH(EW)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_v[g]),
      .pop   (pop_v[g]),
      .wdata (wdata[g]),
      .rdata (head[g]),
      .full  (full_v[g]),
      .empty (empty_v[g]),
      .count (cnt[g])
    );
  end

  // grant: the locked channel while stalled, else the first non-empty from rr_ptr
  always_comb begin
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = rr_ptr;
    if (locked) begin
      grant = lock_ch;
    end else begin
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= CHANNEL_NUM) idx = idx - CHANNEL_NUM;
        if (!found && !empty_v[idx]) begin
          grant = bank_pkg::ch_id_t'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign any_vld   = ~&empty_v;
  assign hs        = any_vld & rsp_ready;
  assign head_g    = head[grant];
  assign rsp_valid = any_vld;
  assign rsp_ch_id = any_vld ? grant : '0;
  assign rsp_tag   = any_vld ? head_g[EW-1 -: TAG_WIDTH] : '0;
  assign rsp_data  = any_vld ? head_g[DATA_WIDTH-1:0] : '0;
  assign channels_credit_release = credit_rel;

  // per-channel issue match, pop select and protocol violation detection
  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      issue_v[c] = rd_issue_valid && (rd_issue_ch_id == bank_pkg::ch_id_t'(c));
      pop_v[c]   = hs && (grant == bank_pkg::ch_id_t'(c));
      ovr_v[c]   = issue_v[c] && (({1'b0, outstanding[c]} + {1'b0, cnt[c]}) >= CRED_SUM);
      unx_v[c]   = ch_rsp_valid[c] && ((outstanding[c] == '0) || (full_v[c] && !pop_v[c]));
    end
  end

  // outstanding reads: saturate at CREDIT_NUM, never underflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        if (issue_v[c] && !ch_rsp_valid[c]) begin
          if (outstanding[c] != CRED_MAX) outstanding[c] <= outstanding[c] + 1'b1;
        end else if (!issue_v[c] && ch_rsp_valid[c] && outstanding[c] != '0) begin
          outstanding[c] <= outstanding[c] - 1'b1;
        end
      end
    end
  end

  // arbiter pointer, grant lock, credit release pulse and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr             <= '0;
      locked             <= 1'b0;
      lock_ch            <= '0;
      credit_rel         <= '0;
      err_credit_overrun <= 1'b0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      if (hs) rr_ptr <= (int'(grant) == CHANNEL_NUM - 1) ? '0 : grant + 1'b1;
      locked             <= any_vld & ~rsp_ready;
      lock_ch            <= grant;
      credit_rel         <= pop_v;
      err_credit_overrun <= err_credit_overrun | (|ovr_v);
      err_unexpected_rsp <= err_unexpected_rsp | (|unx_v);
    end
  end
endmodule
